// File: rtl/muldiv_unit.sv
// ============================================================================
// muldiv_unit : radix-2 iterative multiply/divide unit with HI/LO registers
// rev 1.0
// ============================================================================
`default_nettype none

module muldiv_unit #(
  parameter int XLEN      = 32,
  parameter bit DIV0_FAST = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            flush,
  input  logic            hi_we,
  input  logic            lo_we,
  input  logic [XLEN-1:0] wdata,
  output logic            busy,
  output logic            done,
  output logic            div_by_zero,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  localparam int            CW       = $clog2(XLEN);
  localparam logic [CW-1:0] CNT_LAST = CW'(XLEN - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [2*XLEN-1:0]   acc_q, acc_d;
  logic [XLEN-1:0]     opnd_q, opnd_d;
  logic                is_div_q, is_div_d;
  logic                neg_res_q, neg_res_d;
  logic                neg_rem_q, neg_rem_d;
  logic                dz_q, dz_d;
  logic [XLEN-1:0]     hi_q, hi_d;
  logic [XLEN-1:0]     lo_q, lo_d;

  // Operand decode at acceptance: op[0]=0 selects the signed variants.
  logic            w_signed, w_is_div, w_a_neg, w_b_neg, w_b_zero, w_accept;
  logic [XLEN-1:0] w_a_mag, w_b_mag;

  assign w_signed = ~op[0];
  assign w_is_div = op[1];
  assign w_a_neg  = w_signed & a[XLEN-1];
  assign w_b_neg  = w_signed & b[XLEN-1];
  assign w_a_mag  = w_a_neg ? -a : a;
  assign w_b_mag  = w_b_neg ? -b : b;
  assign w_b_zero = (b == '0);
  assign w_accept = start & ~flush & (state_q != S_CALC);

  // Multiply: acc = {partial product, remaining multiplier bits}, shift right.
  logic [XLEN:0]     w_mul_sum;
  logic [2*XLEN-1:0] w_mul_next;

  assign w_mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
  assign w_mul_next = {w_mul_sum, acc_q[XLEN-1:1]};

  // Divide (restoring): acc = {remainder, dividend/quotient}, shift left.
  logic [XLEN:0]     w_rem_sh, w_diff;
  logic [2*XLEN-1:0] w_div_next;

  assign w_rem_sh   = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
  assign w_diff     = w_rem_sh - {1'b0, opnd_q};
  assign w_div_next = w_diff[XLEN] ? {w_rem_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                                   : {w_diff[XLEN-1:0],   acc_q[XLEN-2:0], 1'b1};

  logic [2*XLEN-1:0] w_step, w_prod_fix;
  logic [XLEN-1:0]   w_quo_fix, w_rem_fix;

  assign w_step     = is_div_q ? w_div_next : w_mul_next;
  assign w_prod_fix = neg_res_q ? -w_step : w_step;
  assign w_quo_fix  = neg_res_q ? -w_step[XLEN-1:0] : w_step[XLEN-1:0];
  assign w_rem_fix  = neg_rem_q ? -w_step[2*XLEN-1:XLEN] : w_step[2*XLEN-1:XLEN];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    opnd_d    = opnd_q;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    dz_d      = dz_q;
    hi_d      = hi_q;
    lo_d      = lo_q;

    // MTHI/MTLO land only while not busy; results commit only on CALC->FIN.
    if (state_q != S_CALC) begin
      if (hi_we) hi_d = wdata;
      if (lo_we) lo_d = wdata;
    end

    case (state_q)
      S_CALC: begin
        if (flush) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          acc_d = w_step;
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CNT_LAST) begin
            state_d = S_FIN;
            cnt_d   = '0;
            if (!dz_q) begin
              if (is_div_q) begin
                hi_d = w_rem_fix;
                lo_d = w_quo_fix;
              end else begin
                hi_d = w_prod_fix[2*XLEN-1:XLEN];
                lo_d = w_prod_fix[XLEN-1:0];
              end
            end
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        if (w_accept) begin
          is_div_d  = w_is_div;
          neg_res_d = w_a_neg ^ w_b_neg;
          neg_rem_d = w_a_neg;
          dz_d      = w_is_div & w_b_zero;
          cnt_d     = '0;
          opnd_d    = w_is_div ? w_b_mag : w_a_mag;
          acc_d     = {{XLEN{1'b0}}, (w_is_div ? w_a_mag : w_b_mag)};
          state_d   = (w_is_div && w_b_zero && DIV0_FAST) ? S_FIN : S_CALC;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      opnd_q    <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      dz_q      <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      opnd_q    <= opnd_d;
      is_div_q  <= is_div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      dz_q      <= dz_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  assign busy        = (state_q == S_CALC);
  assign done        = (state_q == S_FIN);
  assign div_by_zero = (state_q == S_FIN) & dz_q;
  assign hi          = hi_q;
  assign lo          = lo_q;

endmodule

`default_nettype wire

// File: tb/tb_muldiv_unit.sv
// ============================================================================
// tb_muldiv_unit : randomized self-checking bench for muldiv_unit (XLEN=32)
// rev 1.0
// ============================================================================
`default_nettype none

module tb_muldiv_unit;

  localparam int XLEN = 32;

  logic            clk;
  logic            rst;
  logic            start;
  logic [1:0]      op;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            flush;
  logic            hi_we;
  logic            lo_we;
  logic [XLEN-1:0] wdata;
  logic            busy;
  logic            done;
  logic            div_by_zero;
  logic [XLEN-1:0] hi;
  logic [XLEN-1:0] lo;

  int              n_checks;
  int              n_fail;
  logic [XLEN-1:0] exp_hi;
  logic [XLEN-1:0] exp_lo;

  muldiv_unit #(.XLEN(XLEN), .DIV0_FAST(1'b1)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .flush(flush), .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .busy(busy), .done(done), .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Arithmetic reference: MIPS HI/LO semantics from plain integer operators.
  function automatic void model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                                input logic [31:0] h0, input logic [31:0] l0,
                                output logic [31:0] h, output logic [31:0] l, output bit dz);
    longint      p;
    logic [63:0] pu;
    int          sx, sy;
    dz = 1'b0;
    h  = h0;
    l  = l0;
    case (o)
      2'b00: begin
        p = longint'($signed(x)) * longint'($signed(y));
        h = p[63:32];
        l = p[31:0];
      end
      2'b01: begin
        pu = {32'd0, x} * {32'd0, y};
        h  = pu[63:32];
        l  = pu[31:0];
      end
      2'b10: begin
        if (y == 32'd0) dz = 1'b1;
        else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
          l = 32'h8000_0000;
          h = 32'd0;
        end else begin
          sx = $signed(x);
          sy = $signed(y);
          l  = sx / sy;
          h  = sx % sy;
        end
      end
      default: begin
        if (y == 32'd0) dz = 1'b1;
        else begin
          l = x / y;
          h = x % y;
        end
      end
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    op    = o;
    a     = x;
    b     = y;
    start = 1'b1;
    tick();
    start = 1'b0;
    op    = 2'($urandom);
    a     = $urandom;
    b     = $urandom;
  endtask

  // Called in the cycle after acceptance; returns sampled in the FIN cycle.
  task automatic finish_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                           input string name);
    logic [31:0] eh, el;
    bit          edz;
    model(o, x, y, exp_hi, exp_lo, eh, el, edz);
    if (!edz) begin
      for (int i = 1; i <= XLEN; i++) begin
        n_checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
          n_fail++;
          $display("FAIL %s busy@t+%0d: busy=%b done=%b, expected busy=1 done=0", name, i, busy, done);
        end
        tick();
      end
    end
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b1 || div_by_zero !== edz) begin
      n_fail++;
      $display("FAIL %s done: busy=%b done=%b dz=%b, expected busy=0 done=1 dz=%b",
               name, busy, done, div_by_zero, edz);
    end
    n_checks++;
    if (hi !== eh || lo !== el) begin
      n_fail++;
      $display("FAIL %s result op=%0d a=%h b=%h: hi=%h lo=%h, expected hi=%h lo=%h",
               name, o, x, y, hi, lo, eh, el);
    end
    exp_hi = eh;
    exp_lo = el;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #2 rst = 1'b0;
    #1;
    n_checks++;
    if (hi !== '0 || lo !== '0 || busy !== 1'b0 || done !== 1'b0 || div_by_zero !== 1'b0) begin
      n_fail++;
      $display("FAIL reset: hi=%h lo=%h busy=%b done=%b dz=%b, expected all zero",
               hi, lo, busy, done, div_by_zero);
    end
    tick();
    tick();
    rst    = 1'b1;
    exp_hi = '0;
    exp_lo = '0;
    tick();
  endtask

  task automatic test_vectors();
    issue(2'b00, 32'hFFFF_FFFD, 32'h0000_0007);
    finish_op(2'b00, 32'hFFFF_FFFD, 32'h0000_0007, "mult_neg");
    tick();
    issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
    finish_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
    tick();
    issue(2'b10, 32'd7, 32'hFFFF_FFFE);
    finish_op(2'b10, 32'd7, 32'hFFFF_FFFE, "div_pos_neg");
    tick();
  endtask

  task automatic test_back_to_back();
    issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    finish_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max");
    issue(2'b10, 32'hFFFF_FFF9, 32'd2);
    finish_op(2'b10, 32'hFFFF_FFF9, 32'd2, "b2b_div");
    tick();
  endtask

  task automatic test_mthi_mtlo();
    hi_we = 1'b1; wdata = 32'h11; tick(); hi_we = 1'b0;
    lo_we = 1'b1; wdata = 32'h22; tick(); lo_we = 1'b0;
    n_checks++;
    if (hi !== 32'h11 || lo !== 32'h22) begin
      n_fail++;
      $display("FAIL mthi_mtlo: hi=%h lo=%h, expected hi=00000011 lo=00000022", hi, lo);
    end
    exp_hi = 32'h11;
    exp_lo = 32'h22;
    issue(2'b11, 32'd100, 32'd0);
    finish_op(2'b11, 32'd100, 32'd0, "divu_by0");
    hi_we = 1'b1; wdata = 32'hA5A5_A5A5; tick(); hi_we = 1'b0;
    n_checks++;
    if (hi !== 32'hA5A5_A5A5) begin
      n_fail++;
      $display("FAIL mthi_in_fin: hi=%h, expected a5a5a5a5", hi);
    end
    exp_hi = 32'hA5A5_A5A5;
    lo_we = 1'b1; wdata = 32'h5555_5555;
    issue(2'b01, 32'd3, 32'd5);
    lo_we = 1'b0;
    n_checks++;
    if (lo !== 32'h5555_5555) begin
      n_fail++;
      $display("FAIL mtlo_with_start: lo=%h, expected 55555555", lo);
    end
    exp_lo = 32'h5555_5555;
    finish_op(2'b01, 32'd3, 32'd5, "mtlo_overwrite");
    tick();
  endtask

  task automatic test_random();
    logic [1:0]  o;
    logic [31:0] x, y;
    for (int n = 0; n < 28; n++) begin
      o = 2'($urandom);
      x = $urandom;
      case ($urandom_range(0, 4))
        0:       y = 32'd0;
        1:       y = $urandom_range(1, 15);
        2:       y = -$urandom_range(1, 15);
        3:       y = (n % 2 == 0) ? 32'h8000_0000 : 32'h7FFF_FFFF;
        default: y = $urandom;
      endcase
      issue(o, x, y);
      finish_op(o, x, y, "rand");
      if ($urandom_range(0, 1) == 1) tick();
    end
    tick();
  endtask

  task automatic test_flush();
    bit bad;
    issue(2'b00, 32'h1234_5678, 32'h9ABC_DEF0);
    for (int i = 1; i <= 10; i++) begin
      if (i == 5) begin
        start = 1'b1; op = 2'b11; a = 32'd50; b = 32'd3;
        hi_we = 1'b1; wdata = 32'hDEAD_BEEF;
      end
      if (i == 10) flush = 1'b1;
      n_checks++;
      if (busy !== 1'b1) begin
        n_fail++;
        $display("FAIL flush busy@t+%0d: busy=%b, expected 1", i, busy);
      end
      tick();
      start = 1'b0;
      hi_we = 1'b0;
      flush = 1'b0;
    end
    bad = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (busy !== 1'b0 || done !== 1'b0) bad = 1'b1;
      tick();
    end
    n_checks++;
    if (bad || hi !== exp_hi || lo !== exp_lo) begin
      n_fail++;
      $display("FAIL flush_abort: stray=%b hi=%h lo=%h, expected stray=0 hi=%h lo=%h",
               bad, hi, lo, exp_hi, exp_lo);
    end
    start = 1'b1; flush = 1'b1; op = 2'b01; a = 32'd5; b = 32'd5;
    tick();
    start = 1'b0; flush = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (busy !== 1'b0 || done !== 1'b0) bad = 1'b1;
      tick();
    end
    n_checks++;
    if (bad || hi !== exp_hi || lo !== exp_lo) begin
      n_fail++;
      $display("FAIL flush_vs_start: stray=%b hi=%h lo=%h, expected stray=0 hi=%h lo=%h",
               bad, hi, lo, exp_hi, exp_lo);
    end
  endtask

  task automatic test_reset_mid();
    hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h77; tick();
    hi_we = 1'b0; lo_we = 1'b0;
    exp_hi = 32'h77;
    exp_lo = 32'h77;
    issue(2'b10, 32'd1000, 32'd7);
    for (int i = 1; i < 12; i++) tick();
    rst = 1'b0;
    #1;
    n_checks++;
    if (hi !== '0 || lo !== '0 || busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid: hi=%h lo=%h busy=%b done=%b, expected all zero", hi, lo, busy, done);
    end
    exp_hi = '0;
    exp_lo = '0;
    tick();
    rst = 1'b1;
    issue(2'b11, 32'd9, 32'd4);
    finish_op(2'b11, 32'd9, 32'd4, "divu_after_rst");
    tick();
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    start    = 1'b0;
    op       = 2'b00;
    a        = '0;
    b        = '0;
    flush    = 1'b0;
    hi_we    = 1'b0;
    lo_we    = 1'b0;
    wdata    = '0;
    exp_hi   = '0;
    exp_lo   = '0;
    test_reset();
    test_vectors();
    test_back_to_back();
    test_mthi_mtlo();
    test_random();
    test_flush();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 Parameter XLEN, default 32, operand/result width; SHALL be even and >= 8.
REQ-002 Parameter DIV0_FAST, default 1; when 1, divide-by-zero SHALL complete without iterating.
REQ-003 clk  input  1  single clock; all state changes on posedge clk.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  operation request, sampled on posedge clk.
REQ-006 op  input  2  operation code: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-007 a  input  XLEN  operand rs (multiplicand / dividend).
REQ-008 b  input  XLEN  operand rt (multiplier / divisor).
REQ-009 flush  input  1  abort in-flight operation (pipeline squash).
REQ-010 hi_we  input  1  MTHI write enable.
REQ-011 lo_we  input  1  MTLO write enable.
REQ-012 wdata  input  XLEN  MTHI/MTLO data.
REQ-013 busy  output  1  operation in progress; the pipeline stalls MFHI/MFLO while high.
REQ-014 done  output  1  one-cycle pulse; result committed to hi/lo.
REQ-015 div_by_zero  output  1  one-cycle pulse coincident with done for DIV/DIVU with b==0.
REQ-016 hi  output  XLEN  HI register (MFHI source).
REQ-017 lo  output  XLEN  LO register (MFLO source).

Function
REQ-018 FSM states IDLE, CALC, FIN; done SHALL be high only in FIN.
REQ-019 start SHALL be accepted only in IDLE or FIN; start in CALC SHALL be ignored.
REQ-020 Accepted start at edge t SHALL latch op, a, b; busy SHALL be high from t+1 through t+XLEN; done and updated hi/lo SHALL be visible at t+XLEN+1.
REQ-021 Iteration SHALL be radix-2, one bit per cycle, an XLEN-count counter, on operand magnitudes; sign fix-up SHALL be applied at the FIN transition.
REQ-022 MULT/MULTU SHALL produce the full 2*XLEN product: hi = upper XLEN bits, lo = lower XLEN bits; signed for MULT, unsigned for MULTU.
REQ-023 DIV/DIVU SHALL set lo = quotient, hi = remainder; quotient truncates toward zero, and a nonzero remainder takes the sign of the dividend.
REQ-024 DIV of the most-negative value by -1 SHALL give lo = most-negative value, hi = 0, no flag.
REQ-025 Divide-by-zero with DIV0_FAST=1: start at t -> FIN at t+1 (done, div_by_zero at t+1), busy low throughout, hi/lo unchanged.
REQ-026 Divide-by-zero with DIV0_FAST=0: normal XLEN-cycle latency, div_by_zero with done, hi/lo unchanged.
REQ-027 flush in CALC SHALL return to IDLE at the next edge: busy low, no done, hi/lo unchanged; flush in IDLE/FIN SHALL have no effect except to block a same-cycle start.
REQ-028 flush and start in the same cycle: flush SHALL win; the start is dropped.
REQ-029 hi_we/lo_we SHALL write hi/lo at the next edge when busy is low; while busy is high they SHALL be ignored.
REQ-030 hi_we/lo_we in the same cycle as an accepted start: the write SHALL apply, and the later result SHALL overwrite it.
REQ-031 hi_we/lo_we in the FIN cycle SHALL take priority over nothing (the result was committed on entry to FIN); the write SHALL apply.
REQ-032 Back-to-back: start asserted in the FIN cycle SHALL begin the next operation with no idle cycle.
REQ-033 Operand changes on a/b/op after acceptance SHALL NOT affect the result.

Reset
REQ-034 rst low SHALL asynchronously force: state IDLE, hi=0, lo=0, busy=0, done=0, div_by_zero=0, counter=0.
REQ-035 Reset asserted mid-CALC SHALL discard the operation; after release the unit SHALL accept start on the first edge.

Verification (XLEN=32, DIV0_FAST=1)
REQ-036 MULT a=0xFFFFFFFD b=0x00000007 at t -> busy t+1..t+32, done at t+33, hi=0xFFFFFFFF, lo=0xFFFFFFEB.
REQ-037 MULTU a=b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; start in FIN immediately with DIV a=0xFFFFFFF9 b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF, 32 cycles later.
REQ-038 DIVU a=100 b=0 with hi=0x11, lo=0x22 -> done and div_by_zero at t+1, hi=0x11, lo=0x22, busy never high.
REQ-039 DIV a=0x80000000 b=0xFFFFFFFF -> lo=0x80000000, hi=0, div_by_zero=0.
REQ-040 MULT at t, flush at t+10 -> busy low at t+11, no done, hi/lo unchanged; a start at t+5 is ignored; hi_we at t+5 is ignored.
REQ-041 rst low at t+12 of a DIV -> hi=lo=0, busy=0 immediately; after release, DIVU 9/4 -> lo=2, hi=1.
